hazard_stall_ctrl: RTL

- Pipeline hazard controller for the 5-stage MIPS core: generates PC / IF-ID write enables, the IF-ID flush and the ID-EX bubble.
- Sequences the multi-cycle mult/div unit through a busy FSM.
- Handles the hazards the operand-bypass mux select logic cannot cover:
  - load-use: a lw in EX feeding ID;
  - HI/LO accesses while mult/div is busy;
  - control-flow flush.
- Sits beside the ID stage; its outputs drive the pipeline registers and the mult/div unit.

---
 rtl/hazard_stall_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/hazard_stall_ctrl.sv
// Hazard controller beside ID: load-use and HI/LO stalls, branch flush,
// and the mult/div busy sequencer with a stall performance counter.
module hazard_stall_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 16,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op_id,
  input  logic [5:0]       func_id,
  input  logic [4:0]       Rs_id,
  input  logic [4:0]       Rt_id,
  input  logic [5:0]       op_ex,
  input  logic [4:0]       Rw_ex,
  input  logic             br_taken_id,
  output logic             pc_wr,
  output logic             ifid_wr,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             md_start,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_MFHI = 6'b010000;
  localparam logic [5:0] FN_MFLO = 6'b010010;

  localparam logic [4:0] MUL_LD = 5'(MUL_CYCLES);
  localparam logic [4:0] DIV_LD = 5'(DIV_CYCLES);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q;
  logic [4:0]       cnt_q;
  logic [CNT_W-1:0] stall_cnt_q;

  logic rtype;
  logic uses_rs;
  logic uses_rt;
  logic md_op;
  logic hilo_op;
  logic is_div;
  logic rs_hit;
  logic rt_hit;
  logic load_stall;
  logic md_stall;
  logic stall;

  assign rtype = (op_id == OP_RTYPE);

  always_comb begin
    uses_rs = 1'b1;
    unique case (1'b1)
      (op_id == OP_J),
      (op_id == OP_JAL),
      (op_id == OP_LUI): uses_rs = 1'b0;
      rtype: begin
        if (func_id == FN_SLL || func_id == FN_SRL ||
            func_id == FN_SRA || func_id == FN_MFHI ||
            func_id == FN_MFLO)
          uses_rs = 1'b0;
      end
      default: uses_rs = 1'b1;
    endcase
  end

  always_comb begin
    uses_rt = 1'b0;
    unique case (op_id)
      OP_RTYPE, OP_BEQ, OP_BNE,
      OP_SW, OP_SH, OP_SB: uses_rt = 1'b1;
      default:             uses_rt = 1'b0;
    endcase
  end

  // mult/multu/div/divu share funct[5:2]; funct[1] selects divide
  assign md_op   = rtype && (func_id[5:2] == 4'b0110);
  assign hilo_op = rtype && (func_id[5:2] == 4'b0100);
  assign is_div  = func_id[1];

  // $0 is never written, so it can never be a load-use source
  assign rs_hit = uses_rs && (Rs_id == Rw_ex);
  assign rt_hit = uses_rt && (Rt_id == Rw_ex);

  assign load_stall = (op_ex == OP_LW) && (Rw_ex != 5'd0) &&
                      (rs_hit || rt_hit);
  assign md_stall   = md_busy && (md_op || hilo_op);
  assign stall      = load_stall || md_stall;

  assign pc_wr       = !rst && !stall;
  assign ifid_wr     = !rst && !stall;
  assign idex_bubble = !rst && stall;
  assign ifid_flush  = !rst && br_taken_id && !stall;
  assign md_start    = !rst && md_op && !stall;

  assign md_busy   = (state_q == BUSY);
  assign md_done   = !rst && md_busy && (cnt_q == 5'd1);
  assign stall_cnt = stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (md_start) begin
            cnt_q   <= is_div ? DIV_LD : MUL_LD;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd1)
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt_q <= '0;
    else if (stall)
      stall_cnt_q <= stall_cnt_q + 1'b1;
  end

endmodule
